// File: rtl/data_mem_responder.sv
// Data-memory responder for the CPU load/store path: byte/half/word access with lane extend.
// Response valid WAIT_CYCLES+1 edges after accept; one request in flight, held in RESP until resp_ready.
module data_mem_responder #(
   parameter int ADDR_W      = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int CNT_W = $clog2(WAIT_CYCLES + 2);
   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

   state_t             r_state;
   state_t             w_next;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_we;
   logic               r_uns;
   logic [1:0]         r_size;
   logic [ADDR_W+1:0]  r_addr;
   logic [31:0]        r_wdata;
   logic [31:0]        r_rdata;
   logic               r_err;
   logic [31:0]        r_mem [DEPTH];

   logic               w_accept;
   logic               w_commit;
   logic               w_err;
   logic               w_mem_we;
   logic [ADDR_W-1:0]  w_idx;
   logic [31:0]        w_rd_word;
   logic [7:0]         w_byte;
   logic [15:0]        w_half;
   logic [31:0]        w_load;
   logic [3:0]         w_be;
   logic [31:0]        w_wlane;
   logic               w_unused_addr;

   // Upper address bits alias away; only the low ADDR_W+2 bits are kept.
   assign w_unused_addr = |req_addr[31:ADDR_W+2];

   assign req_ready  = (r_state == S_IDLE);
   assign resp_valid = (r_state == S_RESP);
   assign resp_rdata = r_rdata;
   assign resp_err   = r_err;

   assign w_accept  = req_valid && req_ready;
   assign w_commit  = (r_state == S_BUSY) && (r_cnt == '0);
   assign w_idx     = r_addr[ADDR_W+1:2];
   assign w_rd_word = r_mem[w_idx];
   assign w_err     = (r_size == 2'b11)
                   || ((r_size == 2'b01) && r_addr[0])
                   || ((r_size == 2'b10) && (r_addr[1:0] != 2'b00));
   assign w_mem_we  = w_commit && r_we && !w_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next = S_BUSY;
         S_BUSY:  if (r_cnt == '0) w_next = S_RESP;
         S_RESP:  if (resp_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_byte = w_rd_word[{r_addr[1:0], 3'b000} +: 8];
      w_half = r_addr[1] ? w_rd_word[31:16] : w_rd_word[15:0];
      case (r_size)
         2'b00:   w_load = {{24{~r_uns & w_byte[7]}}, w_byte};
         2'b01:   w_load = {{16{~r_uns & w_half[15]}}, w_half};
         default: w_load = w_rd_word;
      endcase
   end

   // Store data is replicated across lanes so the byte enables alone pick the target.
   always_comb begin
      w_be    = 4'b0000;
      w_wlane = r_wdata;
      case (r_size)
         2'b00: begin
            w_be    = 4'b0001 << r_addr[1:0];
            w_wlane = {4{r_wdata[7:0]}};
         end
         2'b01: begin
            w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
            w_wlane = {2{r_wdata[15:0]}};
         end
         2'b10:   w_be = 4'b1111;
         default: w_be = 4'b0000;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_we    <= 1'b0;
         r_uns   <= 1'b0;
         r_size  <= 2'b00;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_we    <= req_we;
            r_uns   <= req_unsigned;
            r_size  <= req_size;
            r_addr  <= req_addr[ADDR_W+1:0];
            r_wdata <= req_wdata;
            r_cnt   <= CNT_W'(WAIT_CYCLES);
         end else if ((r_state == S_BUSY) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
         end
         if (w_commit) begin
            r_rdata <= (w_err || r_we) ? 32'h0 : w_load;
            r_err   <= w_err;
         end
      end
   end

   // Storage is deliberately not reset; writes only happen on a clean commit.
   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wlane[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: load/store lanes, errors, stall and mid-op reset.
module tb_data_mem_responder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_rdata;
   logic        resp_err;

   int n_checks = 0;
   int n_errors = 0;

   localparam int EXP_LAT = 3;

   data_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
      .req_unsigned(req_unsigned),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err)
   );

   always #5 clk = ~clk;

   task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic uns,
                       output logic [31:0] rdata, output logic err, output int lat);
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
      req_size = size; req_unsigned = uns;
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0;
      while (!resp_valid && lat < 20) begin
         @(posedge clk);
         #1 lat++;
      end
      rdata = resp_rdata;
      err   = resp_err;
      n_checks++;
      if (resp_valid !== 1'b1) begin
         n_errors++;
         $display("FAIL resp_timeout addr=%h got resp_valid=%b want 1", addr, resp_valid);
      end
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      n_checks += 4;
      if (req_ready !== 1'b1) begin n_errors++; $display("FAIL rst_req_ready got %b want 1", req_ready); end
      if (resp_valid !== 1'b0) begin n_errors++; $display("FAIL rst_resp_valid got %b want 0", resp_valid); end
      if (resp_rdata !== 32'h0) begin n_errors++; $display("FAIL rst_rdata got %h want 0", resp_rdata); end
      if (resp_err !== 1'b0) begin n_errors++; $display("FAIL rst_err got %b want 0", resp_err); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_word();
      logic [31:0] rd; logic er; int lat;
      xact(1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, rd, er, lat);
      n_checks += 3;
      if (rd !== 32'h0) begin n_errors++; $display("FAIL sw_rdata got %h want 0", rd); end
      if (er !== 1'b0) begin n_errors++; $display("FAIL sw_err got %b want 0", er); end
      if (lat != EXP_LAT) begin n_errors++; $display("FAIL sw_latency got %0d want %0d", lat, EXP_LAT); end
      xact(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, er, lat);
      n_checks += 3;
      if (rd !== 32'hDEADBEEF) begin n_errors++; $display("FAIL lw_rdata got %h want deadbeef", rd); end
      if (er !== 1'b0) begin n_errors++; $display("FAIL lw_err got %b want 0", er); end
      if (lat != EXP_LAT) begin n_errors++; $display("FAIL lw_latency got %0d want %0d", lat, EXP_LAT); end
   endtask

   task automatic test_byte();
      logic [31:0] rd; logic er; int lat;
      xact(1'b1, 32'h11, 32'h00000080, 2'b00, 1'b0, rd, er, lat);
      xact(1'b0, 32'h11, 32'h0, 2'b00, 1'b0, rd, er, lat);
      n_checks++;
      if (rd !== 32'hFFFFFF80) begin n_errors++; $display("FAIL lb_rdata got %h want ffffff80", rd); end
      xact(1'b0, 32'h11, 32'h0, 2'b00, 1'b1, rd, er, lat);
      n_checks++;
      if (rd !== 32'h00000080) begin n_errors++; $display("FAIL lbu_rdata got %h want 00000080", rd); end
      xact(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, er, lat);
      n_checks++;
      if (rd !== 32'hDEAD80EF) begin n_errors++; $display("FAIL sb_merge got %h want dead80ef", rd); end
   endtask

   task automatic test_half();
      logic [31:0] rd; logic er; int lat;
      xact(1'b1, 32'h12, 32'h00008001, 2'b01, 1'b0, rd, er, lat);
      xact(1'b0, 32'h12, 32'h0, 2'b01, 1'b0, rd, er, lat);
      n_checks++;
      if (rd !== 32'hFFFF8001) begin n_errors++; $display("FAIL lh_rdata got %h want ffff8001", rd); end
      xact(1'b0, 32'h12, 32'h0, 2'b01, 1'b1, rd, er, lat);
      n_checks++;
      if (rd !== 32'h00008001) begin n_errors++; $display("FAIL lhu_rdata got %h want 00008001", rd); end
      xact(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, er, lat);
      n_checks++;
      if (rd !== 32'h800180EF) begin n_errors++; $display("FAIL sh_merge got %h want 800180ef", rd); end
      // 0x1010 aliases onto 0x10 with a 4 KiB address space.
      xact(1'b0, 32'h00001010, 32'h0, 2'b10, 1'b0, rd, er, lat);
      n_checks++;
      if (rd !== 32'h800180EF) begin n_errors++; $display("FAIL alias_rdata got %h want 800180ef", rd); end
   endtask

   task automatic test_errors();
      logic [31:0] rd; logic er; int lat;
      xact(1'b0, 32'h13, 32'h0, 2'b10, 1'b0, rd, er, lat);
      n_checks += 3;
      if (er !== 1'b1) begin n_errors++; $display("FAIL lw_mis_err got %b want 1", er); end
      if (rd !== 32'h0) begin n_errors++; $display("FAIL lw_mis_rdata got %h want 0", rd); end
      if (lat != EXP_LAT) begin n_errors++; $display("FAIL err_latency got %0d want %0d", lat, EXP_LAT); end
      xact(1'b0, 32'h10, 32'h0, 2'b11, 1'b0, rd, er, lat);
      n_checks += 2;
      if (er !== 1'b1) begin n_errors++; $display("FAIL size11_err got %b want 1", er); end
      if (rd !== 32'h0) begin n_errors++; $display("FAIL size11_rdata got %h want 0", rd); end
      xact(1'b1, 32'h11, 32'h0000FFFF, 2'b01, 1'b0, rd, er, lat);
      n_checks++;
      if (er !== 1'b1) begin n_errors++; $display("FAIL sh_mis_err got %b want 1", er); end
      xact(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, er, lat);
      n_checks += 2;
      if (rd !== 32'h800180EF) begin n_errors++; $display("FAIL sh_mis_nowrite got %h want 800180ef", rd); end
      if (er !== 1'b0) begin n_errors++; $display("FAIL lw_after_err got %b want 0", er); end
   endtask

   task automatic test_stall();
      logic [31:0] rd; logic er; int lat;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_size = 2'b10; req_unsigned = 1'b0;
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0;
      while (!resp_valid && lat < 20) begin
         @(posedge clk);
         #1 lat++;
      end
      for (int i = 0; i < 5; i++) begin
         if (i == 1) begin
            req_valid = 1'b1; req_we = 1'b1; req_wdata = 32'h0; req_addr = 32'h10; req_size = 2'b10;
         end
         @(posedge clk);
         #1 req_valid = 1'b0;
         n_checks += 4;
         if (resp_valid !== 1'b1) begin n_errors++; $display("FAIL stall_valid[%0d] got %b want 1", i, resp_valid); end
         if (resp_rdata !== 32'h800180EF) begin n_errors++; $display("FAIL stall_rdata[%0d] got %h want 800180ef", i, resp_rdata); end
         if (resp_err !== 1'b0) begin n_errors++; $display("FAIL stall_err[%0d] got %b want 0", i, resp_err); end
         if (req_ready !== 1'b0) begin n_errors++; $display("FAIL stall_req_ready[%0d] got %b want 0", i, req_ready); end
      end
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
      n_checks += 2;
      if (resp_valid !== 1'b0) begin n_errors++; $display("FAIL stall_release_valid got %b want 0", resp_valid); end
      if (req_ready !== 1'b1) begin n_errors++; $display("FAIL stall_release_ready got %b want 1", req_ready); end
      xact(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, er, lat);
      n_checks++;
      if (rd !== 32'h800180EF) begin n_errors++; $display("FAIL stall_ignored_store got %h want 800180ef", rd); end
   endtask

   task automatic test_reset_midop();
      logic [31:0] rd; logic er; int lat;
      xact(1'b1, 32'h20, 32'hCAFEF00D, 2'b10, 1'b0, rd, er, lat);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_size = 2'b10;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      n_checks += 2;
      if (resp_valid !== 1'b0) begin n_errors++; $display("FAIL midrst_valid got %b want 0", resp_valid); end
      if (req_ready !== 1'b1) begin n_errors++; $display("FAIL midrst_ready got %b want 1", req_ready); end
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      xact(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, rd, er, lat);
      n_checks++;
      if (rd !== 32'hCAFEF00D) begin n_errors++; $display("FAIL midrst_nowrite got %h want cafef00d", rd); end
   endtask

   initial begin
      test_reset();
      test_word();
      test_byte();
      test_half();
      test_errors();
      test_stall();
      test_reset_midop();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
